// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
// Optional saturating output is enabled by defining PIPE_ADDER_SAT_EN.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Per-stage control state that travels alongside the datapath registers.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int chunk_width(input int width, input int stages);
    return (stages >= 1) ? width / stages : width;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds the next CHUNK bits of the operands plus the
// incoming carry, merges them into the partial sum and registers everything.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_valid,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  stage_ctrl_t      r_ctrl;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [CHUNK-1:0] w_chunk;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum;

  assign {w_carry, w_chunk} = {1'b0, i_a[CHUNK-1:0]} + {1'b0, i_b[CHUNK-1:0]}
                            + {{CHUNK{1'b0}}, i_carry};

  // Bits at and above this chunk's slot are still zero in i_sum, so OR-ing
  // the new chunk in is an insertion.
  assign w_sum = i_sum | (WIDTH'(w_chunk) << (IDX * CHUNK));

  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; the payload is reset too, because an idle
  // pipe must present sum = 0 and cout = 0 until the first result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_sum  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (i_advance) begin
      r_ctrl.valid <= i_valid;
      if (i_valid) begin
        r_ctrl.carry <= w_carry;
        r_sum        <= w_sum;
        r_a          <= i_a >> CHUNK;
        r_b          <= i_b >> CHUNK;
      end
    end
  end

  assign o_valid = r_ctrl.valid;
  assign o_carry = r_ctrl.carry;
  assign o_sum   = r_sum;
  assign o_a     = r_a;
  assign o_b     = r_b;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit ripple-carry adder split over STAGES valid/ready pipeline stages.
// Define PIPE_ADDER_SAT_EN to clamp sum to all ones whenever cout is set.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             w_valid [0:STAGES];
  logic             w_carry [0:STAGES];
  logic [WIDTH-1:0] w_sum   [0:STAGES];
  logic [WIDTH-1:0] w_a     [0:STAGES];
  logic [WIDTH-1:0] w_b     [0:STAGES];
  logic [STAGES:0]  w_advance;
  logic [2*WIDTH-1:0] w_unused_ops;

  assign w_valid[0] = bus.in_valid;
  assign w_carry[0] = bus.cin;
  assign w_sum[0]   = '0;
  assign w_a[0]     = bus.a;
  assign w_b[0]     = bus.b;

  // NOTE: every bit gets a value on every pass, so this stays pure
  // combinational logic with no inferred latch.
  always_comb begin
    w_advance         = '0;
    w_advance[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_advance[k] = !w_valid[k+1] || w_advance[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .IDX  (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_advance(w_advance[k]),
      .i_valid  (w_valid[k]),
      .i_carry  (w_carry[k]),
      .i_sum    (w_sum[k]),
      .i_a      (w_a[k]),
      .i_b      (w_b[k]),
      .o_valid  (w_valid[k+1]),
      .o_carry  (w_carry[k+1]),
      .o_sum    (w_sum[k+1]),
      .o_a      (w_a[k+1]),
      .o_b      (w_b[k+1])
    );
  end

  // All operand bits are consumed by the last stage; its leftovers are empty.
  assign w_unused_ops = {w_a[STAGES], w_b[STAGES]};

  assign bus.in_ready  = w_advance[0];
  assign bus.out_valid = w_valid[STAGES];
  assign bus.cout      = w_carry[STAGES];
`ifdef PIPE_ADDER_SAT_EN
  assign bus.sum = w_carry[STAGES] ? '1 : w_sum[STAGES];
`else
  assign bus.sum = w_sum[STAGES];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 16-bit/4-stage adder against a queue model, plus an
// exhaustive sweep of a 4-bit/1-stage instance.
module tb_pipelined_adder;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16.slave)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_add16(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'd0, c};
    if (SAT && s[16]) s[15:0] = 16'hFFFF;
    return s;
  endfunction

  function automatic logic [4:0] ref_add4(input logic [3:0] a, input logic [3:0] b,
                                          input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (SAT && s[4]) s[3:0] = 4'hF;
    return s;
  endfunction

  // Scoreboard for the 16-bit instance: sampled mid-cycle, away from edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus16.out_valid) begin
        check("stream_item_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("stream_result", {15'd0, bus16.cout, bus16.sum}, {15'd0, exp_q[0]});
          if (bus16.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus16.in_valid && bus16.in_ready)
        exp_q.push_back(ref_add16(bus16.a, bus16.b, bus16.cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    bus16.in_valid = v;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = c;
  endtask

  task automatic step16(output bit acc);
    @(negedge clk);
    acc = bus16.in_valid && bus16.in_ready;
    @(posedge clk);
    #1;
  endtask

  // Present one item to an idle pipe and count edges until out_valid rises.
  task automatic one_shot(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int lat);
    drive16(1'b1, a, b, c);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 1) drive16(1'b0, 16'd0, 16'd0, 1'b0);
      if (bus16.out_valid) break;
    end
  endtask

  logic [15:0] bp_a   [6] = '{16'h0001, 16'h1000, 16'h00FF, 16'h8000, 16'h1111, 16'hFFFE};
  logic [15:0] bp_b   [6] = '{16'h0001, 16'h2000, 16'h0001, 16'h8000, 16'h1111, 16'h0001};
  logic        bp_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [16:0] bp_exp [6];

  initial begin
    int          lat;
    int          idx;
    int          sent;
    int          cyc;
    bit          acc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    bp_exp = '{17'h00002, 17'h03000, 17'h00100,
               SAT ? 17'h1FFFF : 17'h10000, 17'h02223, 17'h0FFFF};

    rst_n           = 1'b0;
    drive16(1'b0, 16'd0, 16'd0, 1'b0);
    bus16.out_ready = 1'b1;
    bus4.in_valid   = 1'b0;
    bus4.a          = 4'd0;
    bus4.b          = 4'd0;
    bus4.cin        = 1'b0;
    bus4.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_sum",       32'(bus16.sum),       32'd0);
    check("rst_cout",      32'(bus16.cout),      32'd0);
    check("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    check("rst4_outputs",  {27'd0, bus4.out_valid, bus4.cout, bus4.sum[2:0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic add and latency.
    one_shot(16'h1234, 16'h4321, 1'b0, lat);
    check("lat_cycles", 32'(lat), 32'd4);
    check("lat_result", {15'd0, bus16.cout, bus16.sum}, 32'h05555);
    tick();

    // Carry ripples through every chunk.
    one_shot(16'hFFFF, 16'h0000, 1'b1, lat);
    check("carry_cycles", 32'(lat), 32'd4);
    check("carry_result", {15'd0, bus16.cout, bus16.sum},
          SAT ? 32'h1FFFF : 32'h10000);
    tick();

    // Backpressure: four items fill the pipe, the fifth is refused.
    bus16.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) drive16(1'b1, bp_a[idx], bp_b[idx], bp_c[idx]);
      step16(acc);
      if (acc) idx++;
    end
    drive16(1'b1, bp_a[idx], bp_b[idx], bp_c[idx]);
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_in_ready", 32'(bus16.in_ready), 32'd0);
    check("bp_held", {15'd0, bus16.cout, bus16.sum}, {15'd0, bp_exp[0]});
    bus16.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (idx < 6) drive16(1'b1, bp_a[idx], bp_b[idx], bp_c[idx]);
      else         drive16(1'b0, 16'd0, 16'd0, 1'b0);
      @(negedge clk);
      check("bp_drain", {14'd0, bus16.out_valid, bus16.cout, bus16.sum},
            {14'd0, 1'b1, bp_exp[j]});
      acc = bus16.in_valid && bus16.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    drive16(1'b0, 16'd0, 16'd0, 1'b0);
    check("bp_all_sent", 32'(idx), 32'd6);
    tick();
    check("bp_empty_after", 32'(bus16.out_valid), 32'd0);

    // Random streaming with ~70% out_ready.
    sent = 0;
    cyc  = 0;
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom);
    while (sent < 1000 && cyc < 20000) begin
      bus16.out_ready = ($urandom_range(0, 9) < 7);
      drive16(1'b1, ra, rb, rc);
      step16(acc);
      cyc++;
      if (acc) begin
        sent++;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
      end
    end
    check("stream_sent", 32'(sent), 32'd1000);
    drive16(1'b0, 16'd0, 16'd0, 1'b0);
    bus16.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Steady stream: one item per cycle with out_ready held high.
    for (int i = 0; i < 64; i++) begin
      drive16(1'b1, 16'(i * 977), 16'(i * 31), 1'(i));
      check("steady_in_ready", 32'(bus16.in_ready), 32'd1);
      step16(acc);
      if (i >= 3) check("steady_out_valid", 32'(bus16.out_valid), 32'd1);
    end
    drive16(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();
    check("steady_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three items in flight.
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, 16'(16'h0100 * (i + 1)), 16'h0011, 1'b0);
      step16(acc);
    end
    drive16(1'b0, 16'd0, 16'd0, 1'b0);
    tick();
    tick();
    check("midrst_pre_valid", 32'(bus16.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("midrst_sum",       32'(bus16.sum),       32'd0);
    check("midrst_cout",      32'(bus16.cout),      32'd0);
    check("midrst_in_ready",  32'(bus16.in_ready),  32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_stale", 32'(bus16.out_valid), 32'd0);
    end

    // Exhaustive 4-bit, single-stage instance.
    for (int i = 0; i < 512; i++) begin
      bus4.in_valid = 1'b1;
      bus4.a        = i[3:0];
      bus4.b        = i[7:4];
      bus4.cin      = i[8];
      tick();
      check("exh4", {26'd0, bus4.out_valid, bus4.cout, bus4.sum},
            {26'd0, 1'b1, ref_add4(i[3:0], i[7:4], i[8])});
    end
    bus4.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
